// File: rtl/pll_lock_detect_if.sv
// Signal bundle between the PLL lock monitor and its host.
// The host drives REF and CLR; the monitor drives the lock and period status.
interface pll_lock_detect_if #(
   parameter int unsigned CNT_W = 8
);
   logic             REF;
   logic             CLR;
   logic             LOCK;
   logic [CNT_W-1:0] REF_PERIOD;
   logic             PERIOD_VALID;
   logic             REF_LOST;
   logic             LOSS_STICKY;

   modport master (
      output REF,
      output CLR,
      input  LOCK,
      input  REF_PERIOD,
      input  PERIOD_VALID,
      input  REF_LOST,
      input  LOSS_STICKY
   );

   modport slave (
      input  REF,
      input  CLR,
      output LOCK,
      output REF_PERIOD,
      output PERIOD_VALID,
      output REF_LOST,
      output LOSS_STICKY
   );
endinterface

// File: rtl/pll_lock_detect.sv
// PLL lock monitor: measures the synchronised REF period in CLK cycles and
// declares lock after a run of in-tolerance periods; flags loss of reference.
module pll_lock_detect #(
   parameter int unsigned RATIO      = 8,
   parameter int unsigned TOL        = 1,
   parameter int unsigned LOCK_CNT   = 4,
   parameter int unsigned UNLOCK_CNT = 2,
   parameter int unsigned TIMEOUT    = 64,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             CLK,
   input  logic             RSTb,
   pll_lock_detect_if.slave bus
);

   localparam int unsigned MEAS_W = CNT_W + 1;
   localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int unsigned BAD_W  = $clog2(UNLOCK_CNT + 1);
   localparam int unsigned SYNC_N = 3;

   localparam logic [CNT_W-1:0]  CNT_MAX = '1;
   localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [MEAS_W-1:0] RATIO_M = MEAS_W'(RATIO);
   localparam logic [MEAS_W-1:0] TOL_M   = MEAS_W'(TOL);
   localparam logic [GOOD_W-1:0] GOOD_TH = GOOD_W'(LOCK_CNT);
   localparam logic [BAD_W-1:0]  BAD_TH  = BAD_W'(UNLOCK_CNT);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEARCH,
      ST_LOCKED,
      ST_HOLD
   } state_t;

   state_t              state_q, state_d;
   logic [SYNC_N-1:0]   sync_q, sync_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [GOOD_W-1:0]   good_q, good_d;
   logic [BAD_W-1:0]    bad_q, bad_d;
   logic                armed_q, armed_d;
   logic                lock_q, lock_d;
   logic [CNT_W-1:0]    period_q, period_d;
   logic                pvalid_q, pvalid_d;
   logic                ref_lost_q, ref_lost_d;
   logic                sticky_q, sticky_d;

   logic                rise;
   logic                measure;
   logic                timeout;
   logic                is_match;
   logic [MEAS_W-1:0]   meas;
   logic [MEAS_W-1:0]   diff;
   logic [GOOD_W-1:0]   good_inc;
   logic [BAD_W-1:0]    bad_inc;

   // Three-stage shift: stages 0/1 resolve metastability, stage 2 is the edge reference.
   assign sync_d[0] = bus.REF;
   generate
      for (genvar gi = 1; gi < SYNC_N; gi++) begin : g_sync
         assign sync_d[gi] = sync_q[gi-1];
      end
   endgenerate

   assign rise    = sync_q[1] & ~sync_q[2];
   assign measure = rise & armed_q;
   // Rise has priority: a REF edge landing on the last count cancels the timeout.
   assign timeout = ~rise & (cnt_q == TO_LAST);

   // One extra bit so a saturated counter reads as an out-of-range period.
   assign meas     = {1'b0, cnt_q} + MEAS_W'(1);
   assign diff     = (meas >= RATIO_M) ? (meas - RATIO_M) : (RATIO_M - meas);
   assign is_match = ~meas[MEAS_W-1] & (diff <= TOL_M);
   assign good_inc = good_q + GOOD_W'(1);
   assign bad_inc  = bad_q + BAD_W'(1);

   always_comb begin
      cnt_d = cnt_q;
      if (rise) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      good_d     = good_q;
      bad_d      = bad_q;
      armed_d    = armed_q;
      period_d   = period_q;
      pvalid_d   = 1'b0;
      ref_lost_d = ref_lost_q;

      if (rise) begin
         ref_lost_d = 1'b0;
      end

      if (measure) begin
         pvalid_d = 1'b1;
         period_d = meas[MEAS_W-1] ? CNT_MAX : meas[CNT_W-1:0];
      end

      if (timeout) begin
         state_d    = ST_IDLE;
         armed_d    = 1'b0;
         ref_lost_d = 1'b1;
         good_d     = '0;
         bad_d      = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rise) begin
                  state_d = ST_SEARCH;
                  armed_d = 1'b1;
                  good_d  = '0;
               end
            end
            ST_SEARCH: begin
               if (measure) begin
                  if (is_match) begin
                     good_d = good_inc;
                     if (good_inc == GOOD_TH) begin
                        state_d = ST_LOCKED;
                        bad_d   = '0;
                     end
                  end else begin
                     good_d = '0;
                  end
               end
            end
            ST_LOCKED: begin
               if (measure && !is_match) begin
                  bad_d = BAD_W'(1);
                  if (UNLOCK_CNT == 1) begin
                     state_d = ST_SEARCH;
                     good_d  = '0;
                  end else begin
                     state_d = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (measure) begin
                  if (is_match) begin
                     state_d = ST_LOCKED;
                     bad_d   = '0;
                  end else begin
                     bad_d = bad_inc;
                     if (bad_inc == BAD_TH) begin
                        state_d = ST_SEARCH;
                        good_d  = '0;
                     end
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               armed_d = 1'b0;
            end
         endcase
      end
   end

   // A new loss outranks a simultaneous clear so the event is never missed.
   always_comb begin
      lock_d   = (state_d == ST_LOCKED) || (state_d == ST_HOLD);
      sticky_d = sticky_q;
      if (lock_q && !lock_d) begin
         sticky_d = 1'b1;
      end else if (bus.CLR) begin
         sticky_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         state_q    <= ST_IDLE;
         sync_q     <= '0;
         cnt_q      <= '0;
         good_q     <= '0;
         bad_q      <= '0;
         armed_q    <= 1'b0;
         lock_q     <= 1'b0;
         period_q   <= '0;
         pvalid_q   <= 1'b0;
         ref_lost_q <= 1'b0;
         sticky_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         cnt_q      <= cnt_d;
         good_q     <= good_d;
         bad_q      <= bad_d;
         armed_q    <= armed_d;
         lock_q     <= lock_d;
         period_q   <= period_d;
         pvalid_q   <= pvalid_d;
         ref_lost_q <= ref_lost_d;
         sticky_q   <= sticky_d;
      end
   end

   assign bus.LOCK         = lock_q;
   assign bus.REF_PERIOD   = period_q;
   assign bus.PERIOD_VALID = pvalid_q;
   assign bus.REF_LOST     = ref_lost_q;
   assign bus.LOSS_STICKY  = sticky_q;

endmodule

// File: doc/pll_lock_detect.md
Name: pll_lock_detect

Overview:
- Lock monitor sitting directly downstream of the analog PLL, clocked by the PLL output CLK.
- Samples the reference clock REF (asynchronous to CLK), measures each REF period in CLK cycles, and compares it against the nominal multiplication ratio (8).
- Drives LOCK to gate downstream SoC logic. Flags loss of lock and loss of reference.

Parameters:
- RATIO, 8: expected CLK cycles per REF period.
- TOL, 1: allowed absolute deviation from RATIO that still counts as a match.
- LOCK_CNT, 4: consecutive matching periods required to assert LOCK.
- UNLOCK_CNT, 2: consecutive mismatching periods required to drop LOCK.
- TIMEOUT, 64: CLK cycles with no REF rising edge before reference is declared lost. Must satisfy RATIO+TOL < TIMEOUT <= 2^CNT_W-1.
- CNT_W, 8: width of the period counter and of REF_PERIOD.

Ports:
- CLK  input  1  PLL output clock. Sole clock of the block.
- RSTb  input  1  asynchronous active-low reset; deassertion synchronous to CLK externally.
- REF  input  1  reference clock, asynchronous; synchronised internally.
- CLR  input  1  synchronous clear of LOSS_STICKY.
- LOCK  output  1  PLL considered locked.
- REF_PERIOD  output  CNT_W  last measured REF period in CLK cycles.
- PERIOD_VALID  output  1  one-cycle pulse when REF_PERIOD updates.
- REF_LOST  output  1  no REF edge for TIMEOUT cycles.
- LOSS_STICKY  output  1  set whenever LOCK falls; held until CLR.

Behaviour:
- Reset (RSTb=0, async): all outputs 0, sync flops 0, counters 0, FSM=IDLE.
- Synchroniser: REF -> s1 -> s2 -> s3. The rise event is s2 & ~s3. A REF edge produces rise 2-3 CLK cycles later.
- Period counter (cnt):
  - Cleared to 0 on a rise cycle; increments otherwise.
  - Saturates at 2^CNT_W-1 and never wraps.
- Measurement:
  - On a rise cycle with armed=1, meas = cnt+1.
  - Registered next cycle: REF_PERIOD <= meas and PERIOD_VALID=1 for one cycle.
  - A steady 8-cycle REF period gives REF_PERIOD=8.
  - First rise after reset or after timeout only sets armed=1 and produces no measurement.
- Match rule: |meas - RATIO| <= TOL, computed unsigned without underflow.
- FSM states: IDLE, SEARCH, LOCKED, HOLD. Counters: good (matches), bad (mismatches).
  - IDLE: on rise -> SEARCH; armed=1, good=0.
  - SEARCH: match -> good+1; when good reaches LOCK_CNT -> LOCKED. Mismatch -> good=0.
  - LOCKED: match -> stay. Mismatch -> bad=1; go to SEARCH if UNLOCK_CNT==1, else HOLD.
  - HOLD: match -> LOCKED, bad=0. Mismatch -> bad+1; when bad reaches UNLOCK_CNT -> SEARCH, good=0.
  - Any state: cnt reaches TIMEOUT -> IDLE, armed=0, REF_LOST=1.
- Output timing:
  - LOCK = (state is LOCKED or HOLD), registered. It changes in the same cycle as the PERIOD_VALID pulse of the deciding measurement.
  - REF_LOST clears on the next rise. LOCK falls in the same cycle REF_LOST sets.
  - LOSS_STICKY sets in the cycle LOCK falls, from either a mismatch streak or a timeout.
- Priorities and boundaries:
  - Timeout and rise in the same cycle: rise wins; cnt clears and no timeout fires.
  - CLR and a new loss in the same cycle: LOSS_STICKY stays 1.
  - good and bad saturate at their thresholds.
  - A period that saturates cnt (> 2^CNT_W-1) is a mismatch.
- Reset mid-operation: LOCK drops immediately and asynchronously. After release the block restarts from IDLE and needs 1 arming rise plus LOCK_CNT matches before LOCK returns.

Test Plan:
1. Defaults, REF period = 8 CLK cycles from reset -> PERIOD_VALID pulses with REF_PERIOD=8 starting after the 2nd rise; LOCK=1 with the 4th valid pulse; REF_LOST=0.
2. REF period alternating 9/7 -> LOCK=1 after 4 measurements. REF period 10 -> REF_PERIOD=10 each pulse; LOCK stays 0.
3. Locked at period 8; one period of 11, then 8 -> LOCK stays 1 (HOLD, then LOCKED). Two consecutive 11 -> LOCK=0 at the 2nd pulse; LOSS_STICKY=1; CLR pulse -> LOSS_STICKY=0.
4. Locked, then REF held low -> 64 cycles after the last rise REF_LOST=1, LOCK=0, LOSS_STICKY=1. REF resumes at period 8 -> REF_LOST=0 at the first rise; LOCK returns after 4 further matches.
5. RSTb pulsed low mid-lock, asynchronously to CLK -> LOCK, REF_PERIOD, LOSS_STICKY go 0 with no CLK edge; relock needs the full sequence.
6. CLR asserted in the same cycle LOCK falls -> LOSS_STICKY=1 afterwards.
